// File: rtl/zx_kbd_pkg.sv
// Shared constants, composite-key enum and the scancode-to-matrix lookup for the ZX keyboard.
package zx_kbd_pkg;

  localparam int ROWS  = 8;
  localparam int COLS  = 5;
  localparam int KEYS  = ROWS * COLS;
  localparam int CMP_N = 5;

  localparam logic [2:0] ROW_CAPS = 3'd0;
  localparam logic [2:0] COL_CAPS = 3'd0;
  localparam logic [2:0] ROW_SYM  = 3'd7;
  localparam logic [2:0] COL_SYM  = 3'd1;

  typedef enum logic [2:0] {
    CMP_BKSP  = 3'd0,
    CMP_LEFT  = 3'd1,
    CMP_DOWN  = 3'd2,
    CMP_UP    = 3'd3,
    CMP_RIGHT = 3'd4
  } cmp_e;

  localparam logic [7:0] SC_BKSP  = 8'h66;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_F12   = 8'h07;

  typedef struct packed {
    logic       valid;
    logic       composite;
    logic [2:0] cmp_idx;
    logic [2:0] row;
    logic [2:0] col;
  } kbd_entry_t;

  function automatic logic [5:0] key_bit(input logic [2:0] r, input logic [2:0] c);
    return 6'(r) * 6'd5 + 6'(c);
  endfunction

  function automatic kbd_entry_t key(input logic [2:0] r, input logic [2:0] c);
    kbd_entry_t e;
    e = '0;
    e.valid = 1'b1;
    e.row   = r;
    e.col   = c;
    return e;
  endfunction

  function automatic kbd_entry_t cmp(input cmp_e i);
    kbd_entry_t e;
    e = '0;
    e.valid     = 1'b1;
    e.composite = 1'b1;
    e.cmp_idx   = i;
    return e;
  endfunction

  // CAPS SHIFT plus the digit key each composite PC key stands for
  function automatic logic [KEYS-1:0] cmp_mask(input logic [2:0] idx);
    logic [KEYS-1:0] m;
    m = '0;
    m[key_bit(ROW_CAPS, COL_CAPS)] = 1'b1;
    case (idx)
      CMP_BKSP:  m[key_bit(3'd4, 3'd0)] = 1'b1;
      CMP_LEFT:  m[key_bit(3'd3, 3'd4)] = 1'b1;
      CMP_DOWN:  m[key_bit(3'd4, 3'd4)] = 1'b1;
      CMP_UP:    m[key_bit(3'd4, 3'd3)] = 1'b1;
      CMP_RIGHT: m[key_bit(3'd4, 3'd2)] = 1'b1;
      default:   m = '0;
    endcase
    return m;
  endfunction

  function automatic kbd_entry_t kbd_lookup(input logic [7:0] code);
    kbd_entry_t e;
    e = '0;
    case (code)
      8'h12: e = key(ROW_CAPS, COL_CAPS);
      8'h1A: e = key(3'd0, 3'd1);  8'h22: e = key(3'd0, 3'd2);
      8'h21: e = key(3'd0, 3'd3);  8'h2A: e = key(3'd0, 3'd4);
      8'h1C: e = key(3'd1, 3'd0);  8'h1B: e = key(3'd1, 3'd1);  8'h23: e = key(3'd1, 3'd2);
      8'h2B: e = key(3'd1, 3'd3);  8'h34: e = key(3'd1, 3'd4);
      8'h15: e = key(3'd2, 3'd0);  8'h1D: e = key(3'd2, 3'd1);  8'h24: e = key(3'd2, 3'd2);
      8'h2D: e = key(3'd2, 3'd3);  8'h2C: e = key(3'd2, 3'd4);
      8'h16: e = key(3'd3, 3'd0);  8'h1E: e = key(3'd3, 3'd1);  8'h26: e = key(3'd3, 3'd2);
      8'h25: e = key(3'd3, 3'd3);  8'h2E: e = key(3'd3, 3'd4);
      8'h45: e = key(3'd4, 3'd0);  8'h46: e = key(3'd4, 3'd1);  8'h3E: e = key(3'd4, 3'd2);
      8'h3D: e = key(3'd4, 3'd3);  8'h36: e = key(3'd4, 3'd4);
      8'h4D: e = key(3'd5, 3'd0);  8'h44: e = key(3'd5, 3'd1);  8'h43: e = key(3'd5, 3'd2);
      8'h3C: e = key(3'd5, 3'd3);  8'h35: e = key(3'd5, 3'd4);
      8'h5A: e = key(3'd6, 3'd0);  8'h4B: e = key(3'd6, 3'd1);  8'h42: e = key(3'd6, 3'd2);
      8'h3B: e = key(3'd6, 3'd3);  8'h33: e = key(3'd6, 3'd4);
      8'h29: e = key(3'd7, 3'd0);  8'h14: e = key(ROW_SYM, COL_SYM);
      8'h59: e = key(ROW_SYM, COL_SYM);
      8'h3A: e = key(3'd7, 3'd2);  8'h31: e = key(3'd7, 3'd3);  8'h32: e = key(3'd7, 3'd4);
      SC_BKSP:  e = cmp(CMP_BKSP);
      SC_LEFT:  e = cmp(CMP_LEFT);
      SC_DOWN:  e = cmp(CMP_DOWN);
      SC_UP:    e = cmp(CMP_UP);
      SC_RIGHT: e = cmp(CMP_RIGHT);
      default:  e = '0;
    endcase
    return e;
  endfunction

endpackage

// File: rtl/zx_kbd_if.sv
// PS/2 key-event stream from user_io: one-clock strobe with make/break flag and scancode.
interface zx_kbd_if;
  logic       kstb;
  logic       make;
  logic [7:0] code;

  modport master (output kstb, make, code);
  modport slave  (input  kstb, make, code);
endinterface

// File: rtl/zx_kbd_map.sv
// Combinational scancode decode to a matrix position or composite-key flag.
module zx_kbd_map
  import zx_kbd_pkg::*;
(
  input  logic [7:0] code,
  output kbd_entry_t ent
);
  assign ent = kbd_lookup(code);
endmodule

// File: rtl/zx_keyboard.sv
// ZX Spectrum 8x5 keyboard matrix fed by PS/2 key events; registered active-low column read.
// Optional KBD_JOY_EN: joystick ORed into the matrix as Sinclair-1 (keys 6,7,8,9,0).
module zx_keyboard
  import zx_kbd_pkg::*;
#(
  parameter bit JOY_ACTIVE_LOW = 1'b0
) (
  input  logic            clock,
  input  logic            reset,
  zx_kbd_if.slave         kbd,
  input  logic [7:0]      joy,
  input  logic [7:0]      row,
  output logic [4:0]      col,
  output logic [KEYS-1:0] held
);

  kbd_entry_t      ent;
  logic [KEYS-1:0] held_q;
  logic [CMP_N-1:0] cmp_q;
  logic [KEYS-1:0] eff;
  logic [COLS-1:0] sel_p0;
  logic [COLS-1:0] col_p1;

  zx_kbd_map u_map (
    .code (kbd.code),
    .ent  (ent)
  );

`ifdef KBD_JOY_EN
  logic [7:0] joy_v;
  logic       joy_unused;
  assign joy_v      = joy ^ {8{JOY_ACTIVE_LOW}};
  assign joy_unused = ^joy_v[7:5];
`else
  logic joy_unused;
  assign joy_unused = ^{joy, JOY_ACTIVE_LOW};
`endif

  // make is active-low: a press sets the bit, a break clears it
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      held_q <= '0;
      cmp_q  <= '0;
    end else if (kbd.kstb) begin
      if (kbd.code == SC_F12) begin
        if (!kbd.make) begin
          held_q <= '0;
          cmp_q  <= '0;
        end
      end else if (ent.valid) begin
        if (ent.composite) cmp_q[ent.cmp_idx] <= !kbd.make;
        else               held_q[key_bit(ent.row, ent.col)] <= !kbd.make;
      end
    end
  end

  always_comb begin
    eff = held_q;
    for (int i = 0; i < CMP_N; i++)
      if (cmp_q[i]) eff = eff | cmp_mask(3'(i));
`ifdef KBD_JOY_EN
    eff[20 +: 5] = eff[20 +: 5] | {joy_v[1], joy_v[0], joy_v[2], joy_v[3], joy_v[4]};
`endif
  end

  // p0: OR the selected half-rows
  always_comb begin
    sel_p0 = '0;
    for (int r = 0; r < ROWS; r++)
      if (!row[r]) sel_p0 = sel_p0 | eff[r*COLS +: COLS];
  end

  // p1: registered active-low column read
  always_ff @(posedge clock or posedge reset) begin
    if (reset) col_p1 <= 5'h1F;
    else       col_p1 <= ~sel_p0;
  end

  assign col  = col_p1;
  assign held = held_q;

endmodule
